// File: rtl/cellrv32_bus_switch_pkg.sv
// cellrv32_bus_switch_pkg: shared FSM state type and bus-owner encodings for the bus switch.
`default_nettype none

package cellrv32_bus_switch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_A = 2'd1,
      BUSY_B = 2'd2
   } bus_switch_state_t;

   localparam logic bus_src_a_c = 1'b0;
   localparam logic bus_src_b_c = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cellrv32_bus_switch_port.sv
// cellrv32_bus_switch_port: per-host request capture (pending/write flags) and read-only write error.
`default_nettype none

module cellrv32_bus_switch_port #(
   parameter bit READ_ONLY = 1'b0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic re_i,
   input  logic we_i,
   input  logic done_i,
   output logic req_o,
   output logic wr_o,
   output logic err_o
);

   logic pend;
   logic wr;
   logic ro_err;
   logic strobe;
   logic ro_write;
   logic accept;

   assign strobe   = re_i | we_i;
   assign ro_write = READ_ONLY ? we_i : 1'b0;
   // Strobes while a request is outstanding are protocol violations and are dropped.
   assign accept   = strobe & ~pend & ~ro_write;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pend   <= 1'b0;
         wr     <= 1'b0;
         ro_err <= 1'b0;
      end else begin
         ro_err <= strobe & ~pend & ro_write;
         if (accept) begin
            pend <= 1'b1;
            wr   <= we_i;
         end else if (done_i) begin
            pend <= 1'b0;
         end
      end
   end

   assign req_o = pend | accept;
   assign wr_o  = pend ? wr : we_i;
   assign err_o = ro_err;

endmodule

`default_nettype wire

// File: rtl/cellrv32_bus_switch.sv
// cellrv32_bus_switch: two-host (data A / fetch B) arbiter onto the internal bus, one transfer at a time.
// Optional CELLRV32_BUS_SWITCH_RR_EN selects round-robin instead of fixed A-over-B priority.
`default_nettype none

module cellrv32_bus_switch
   import cellrv32_bus_switch_pkg::*;
#(
   parameter bit PORT_A_READ_ONLY = 1'b0,
   parameter bit PORT_B_READ_ONLY = 1'b1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] a_addr_i,
   input  logic [31:0] a_wdata_i,
   input  logic [3:0]  a_ben_i,
   input  logic        a_re_i,
   input  logic        a_we_i,
   output logic [31:0] a_rdata_o,
   output logic        a_ack_o,
   output logic        a_err_o,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] b_wdata_i,
   input  logic [3:0]  b_ben_i,
   input  logic        b_re_i,
   input  logic        b_we_i,
   output logic [31:0] b_rdata_o,
   output logic        b_ack_o,
   output logic        b_err_o,
   output logic        bus_src_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_ben_o,
   output logic        bus_re_o,
   output logic        bus_we_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   input  logic        bus_err_i
);

   bus_switch_state_t state;
   logic req_a, req_b;
   logic wr_a, wr_b;
   logic ro_err_a, ro_err_b;
   logic done_a, done_b;
   logic busy_a, busy_b;
   logic grant_a, grant_b;
   logic src;
`ifdef CELLRV32_BUS_SWITCH_RR_EN
   logic last_grant;
`endif

   cellrv32_bus_switch_port #(.READ_ONLY(PORT_A_READ_ONLY)) u_port_a (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .re_i   (a_re_i),
      .we_i   (a_we_i),
      .done_i (done_a),
      .req_o  (req_a),
      .wr_o   (wr_a),
      .err_o  (ro_err_a)
   );

   cellrv32_bus_switch_port #(.READ_ONLY(PORT_B_READ_ONLY)) u_port_b (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .re_i   (b_re_i),
      .we_i   (b_we_i),
      .done_i (done_b),
      .req_o  (req_b),
      .wr_o   (wr_b),
      .err_o  (ro_err_b)
   );

   assign busy_a = (state == BUSY_A);
   assign busy_b = (state == BUSY_B);
   assign done_a = busy_a & (bus_ack_i | bus_err_i);
   assign done_b = busy_b & (bus_ack_i | bus_err_i);

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE) begin
`ifdef CELLRV32_BUS_SWITCH_RR_EN
         grant_b = req_b & (~req_a | (last_grant == bus_src_a_c));
`else
         grant_b = req_b & ~req_a;
`endif
         grant_a = req_a & ~grant_b;
      end
   end

   always_comb begin
      src = bus_src_a_c;
      case (state)
         BUSY_A:  src = bus_src_a_c;
         BUSY_B:  src = bus_src_b_c;
         default: src = grant_b ? bus_src_b_c : bus_src_a_c;
      endcase
   end

   assign bus_src_o   = src;
   assign bus_addr_o  = (src == bus_src_b_c) ? b_addr_i  : a_addr_i;
   assign bus_wdata_o = (src == bus_src_b_c) ? b_wdata_i : a_wdata_i;
   assign bus_ben_o   = (src == bus_src_b_c) ? b_ben_i   : a_ben_i;
   assign bus_re_o    = (grant_a & ~wr_a) | (grant_b & ~wr_b);
   assign bus_we_o    = (grant_a &  wr_a) | (grant_b &  wr_b);

   // Error takes precedence over a simultaneous acknowledge.
   assign a_ack_o   = busy_a & bus_ack_i & ~bus_err_i;
   assign a_err_o   = (busy_a & bus_err_i) | ro_err_a;
   assign a_rdata_o = busy_a ? bus_rdata_i : 32'h0;
   assign b_ack_o   = busy_b & bus_ack_i & ~bus_err_i;
   assign b_err_o   = (busy_b & bus_err_i) | ro_err_b;
   assign b_rdata_o = busy_b ? bus_rdata_i : 32'h0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
`ifdef CELLRV32_BUS_SWITCH_RR_EN
         last_grant <= bus_src_a_c;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_a) begin
                  state <= BUSY_A;
               end else if (grant_b) begin
                  state <= BUSY_B;
               end
`ifdef CELLRV32_BUS_SWITCH_RR_EN
               if (grant_a) begin
                  last_grant <= bus_src_a_c;
               end else if (grant_b) begin
                  last_grant <= bus_src_b_c;
               end
`endif
            end
            BUSY_A: begin
               if (done_a) begin
                  state <= IDLE;
               end
            end
            BUSY_B: begin
               if (done_b) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
